// File: rtl/prewish5k_pkg.sv
// Shared definitions for the prewish5k peripherals: handshake states, data width
// and the debounce defaults also used by the button debouncer.
package prewish5k_pkg;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_LATCH,
        HS_ACK
    } hs_state_t;

    localparam int PW5K_DATA_W          = 8;
    localparam int PW5K_SAMPLE_DIV_BITS = 14;
    localparam int PW5K_STABLE_SAMPLES  = 4;

endpackage

// File: rtl/prewish5k_dip_debounce_core.sv
// Two-flop synchronizer, sample-tick divider and whole-vector debouncer.
// Optional change pulse output under PREWISH5K_DIPREAD_CHANGED_EN.
module prewish5k_dip_debounce_core
    import prewish5k_pkg::*;
#(
    parameter int WIDTH           = PW5K_DATA_W,
    parameter int SAMPLE_DIV_BITS = PW5K_SAMPLE_DIV_BITS,
    parameter int STABLE_SAMPLES  = PW5K_STABLE_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
    output logic             changed,
`endif
    output logic [WIDTH-1:0] debounced
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_SAMPLES);

    logic [WIDTH-1:0]           sync1;
    logic [WIDTH-1:0]           sync2;
    logic [WIDTH-1:0]           candidate;
    logic [3:0]                 count;
    logic [3:0]                 count_inc;
    logic [SAMPLE_DIV_BITS-1:0] div;
    logic                       tick;

    assign tick      = &div;
    assign count_inc = count + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            div   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            div   <= div + SAMPLE_DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            candidate <= '0;
            count     <= '0;
            debounced <= '0;
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
            changed   <= 1'b0;
`endif
        end else begin
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
            changed <= 1'b0;
`endif
            if (tick) begin
                if (sync2 != candidate) begin
                    candidate <= sync2;
                    count     <= 4'd1;
                end else if (count < STABLE_C) begin
                    count <= count_inc;
                    // Acceptance happens on the tick that completes the run.
                    if (count_inc == STABLE_C) begin
                        debounced <= candidate;
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
                        changed   <= (candidate != debounced);
`endif
                    end
                end
            end
        end
    end

endmodule

// File: rtl/prewish5k_dipreader.sv
// DIP switch responder: STB_I request -> one-cycle STB_O with masked debounced data.
// Optional o_changed port under PREWISH5K_DIPREAD_CHANGED_EN.
module prewish5k_dipreader
    import prewish5k_pkg::*;
#(
    parameter int SAMPLE_DIV_BITS = PW5K_SAMPLE_DIV_BITS,
    parameter int STABLE_SAMPLES  = PW5K_STABLE_SAMPLES,
    parameter int ALIVE_BITS      = 22
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   STB_I,
    input  logic [PW5K_DATA_W-1:0] DAT_I,
    output logic                   STB_O,
    output logic [PW5K_DATA_W-1:0] DAT_O,
    input  logic [PW5K_DATA_W-1:0] i_switches,
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
    output logic                   o_changed,
`endif
    output logic                   o_alive
);

    hs_state_t              state;
    hs_state_t              state_next;
    logic [PW5K_DATA_W-1:0] mask;
    logic [PW5K_DATA_W-1:0] debounced;
    logic [ALIVE_BITS-1:0]  alive_cnt;

    prewish5k_dip_debounce_core #(
        .WIDTH          (PW5K_DATA_W),
        .SAMPLE_DIV_BITS(SAMPLE_DIV_BITS),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_core (
        .clk      (CLK_I),
        .rst      (RST_I),
        .raw      (i_switches),
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
        .changed  (o_changed),
`endif
        .debounced(debounced)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= HS_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        STB_O      = 1'b0;
        case (state)
            HS_IDLE:  if (STB_I) state_next = HS_LATCH;
            HS_LATCH: state_next = HS_ACK;
            HS_ACK: begin
                STB_O      = 1'b1;
                state_next = HS_IDLE;
            end
            default:  state_next = HS_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mask      <= '0;
            DAT_O     <= '0;
            alive_cnt <= '0;
        end else begin
            alive_cnt <= alive_cnt + ALIVE_BITS'(1);
            if (state == HS_IDLE && STB_I) mask <= DAT_I;
            if (state == HS_LATCH) DAT_O <= debounced & mask;
        end
    end

    assign o_alive = alive_cnt[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_dipreader.sv
// Scoreboard bench for prewish5k_dipreader (tick every 4 clocks, 3 stable samples).
module tb_prewish5k_dipreader;

    logic       clk = 1'b0;
    logic       RST_I = 1'b1;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = '0;
    logic       STB_O;
    logic [7:0] DAT_O;
    logic [7:0] i_switches = '0;
    logic       o_alive;
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
    logic       o_changed;
    int         changed_count = 0;
    int         changed_cyc = -1;
`endif

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   rel = 0;
    int   alive_base = -100;
    int   n_tests = 0;
    int   n_fail = 0;

    prewish5k_dipreader #(
        .SAMPLE_DIV_BITS(2),
        .STABLE_SAMPLES (3),
        .ALIVE_BITS     (4)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (RST_I),
        .STB_I     (STB_I),
        .DAT_I     (DAT_I),
        .STB_O     (STB_O),
        .DAT_O     (DAT_O),
        .i_switches(i_switches),
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
        .o_changed (o_changed),
`endif
        .o_alive   (o_alive)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    // Drives a one-cycle request; the ack is due two cycles later.
    task automatic request(input logic [7:0] m, input logic [7:0] e);
        STB_I = 1'b1;
        DAT_I = m;
        q.push_back('{data: e, cyc: cyc + 2});
        step();
        STB_I = 1'b0;
        DAT_I = '0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            check_eq("ack_stb", {31'b0, STB_O}, 32'd1);
            check_eq("ack_dat", {24'b0, DAT_O}, {24'b0, q[0].data});
            void'(q.pop_front());
        end else begin
            check_eq("idle_stb", {31'b0, STB_O}, 32'd0);
        end
        if (cyc == alive_base + 7)  check_eq("alive_lo", {31'b0, o_alive}, 32'd0);
        if (cyc == alive_base + 8)  check_eq("alive_hi", {31'b0, o_alive}, 32'd1);
        if (cyc == alive_base + 16) check_eq("alive_wrap", {31'b0, o_alive}, 32'd0);
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
        if (o_changed) begin
            changed_count++;
            changed_cyc = cyc;
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int snap;
        repeat (3) step();
        rel        = cyc;
        alive_base = cyc;
        RST_I      = 1'b0;
        i_switches = 8'hA5;

        // Reset state, then debounce boundary (update lands at rel+12)
        request(8'hFF, 8'h00);
        wait_until(rel + 7);
        request(8'hFF, 8'h00);
        wait_until(rel + 10);
        request(8'hFF, 8'h00);   // LATCH coincides with the debounced update
        wait_until(rel + 13);
        request(8'hFF, 8'hA5);
        wait_until(rel + 20);
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
        check_eq("changed_cnt", changed_count, 1);
        check_eq("changed_cyc", changed_cyc, rel + 12);
`endif

        // Mask and single-cycle ack
        c = cyc;
        request(8'h0F, 8'h05);
        wait_until(c + 3);
        check_eq("ack_len", {31'b0, STB_O}, 32'd0);
        request(8'h3C, 8'h24);
        step();
        step();

        // Glitch of two cycles whose synchronized copy covers one tick
        while (((cyc - rel) % 4) != 0) step();
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
        snap = changed_count;
`else
        snap = 0;
`endif
        i_switches = 8'h5A;
        step();
        step();
        i_switches = 8'hA5;
        repeat (24) step();
        request(8'hFF, 8'hA5);
        step();
        step();
`ifdef PREWISH5K_DIPREAD_CHANGED_EN
        check_eq("glitch_changed", changed_count, snap);
`else
        check_eq("glitch_snap", snap, 0);
`endif

        // Back-to-back strobes: one ack, then re-request at n+3
        c = cyc;
        STB_I = 1'b1;
        DAT_I = 8'hFF;
        q.push_back('{data: 8'hA5, cyc: c + 2});
        step();
        step();
        STB_I = 1'b0;
        DAT_I = '0;
        step();
        request(8'hC3, 8'h81);
        repeat (4) step();

        // Reset mid-handshake
        STB_I = 1'b1;
        DAT_I = 8'hFF;
        step();
        STB_I = 1'b0;
        DAT_I = '0;
        RST_I = 1'b1;
        step();
        RST_I = 1'b0;
        check_eq("abort_stb", {31'b0, STB_O}, 32'd0);
        check_eq("abort_dat", {24'b0, DAT_O}, 32'd0);
        repeat (4) step();

        check_eq("pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
